toggle_handshake_receiver: RTL and testbench

//  Receiving end of the two-phase (toggle) handshake whose sender drives a
//  T-flip-flop request line: each Req_Toggle level change announces one data

---
 rtl/toggle_handshake_receiver.sv | 138 +++++++++++++
 tb/tb_toggle_handshake_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_handshake_receiver.sv
// Receiving end of a two-phase toggle handshake: synchronises the request toggle,
// buffers each announced word in a small FIFO and returns one ack toggle per accepted word.
module toggle_handshake_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         i_clock,
    input  logic                         i_clear,
    input  logic                         i_req_toggle,
    input  logic [DATA_WIDTH-1:0]        i_data_in,
    output logic                         o_ack_toggle,
    output logic                         o_out_valid,
    output logic [DATA_WIDTH-1:0]        o_out_data,
    input  logic                         i_out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
    output logic                         o_protocol_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // state     | meaning
    // S_IDLE    | waiting for a request toggle; FIFO has room or gets room this edge
    // S_PENDING | FIFO was full when a word arrived; word parked in r_hold, ack withheld
    typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_req_seen;
    logic                    r_ack;
    logic                    r_error;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [CW-1:0]           r_count;

    logic                    w_req_sync;
    logic                    w_toggle_det;
    logic                    w_pop;
    logic                    w_has_space;
    logic                    w_push;
    logic                    w_push_hold;
    logic                    w_load_hold;
    logic                    w_set_error;
    logic [DATA_WIDTH-1:0]   w_wr_data;

    assign w_req_sync   = r_sync[SYNC_STAGES-1];
    assign w_toggle_det = w_req_sync ^ r_req_seen;
    assign w_pop        = o_out_valid && i_out_ready;
    assign w_has_space  = (r_count < CW'(DEPTH)) || w_pop;
    assign w_wr_data    = w_push_hold ? r_hold : i_data_in;

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (w_toggle_det && !w_has_space) w_next_state = S_PENDING;
            S_PENDING: if (w_pop) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_push_hold = 1'b0;
        w_load_hold = 1'b0;
        w_set_error = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_toggle_det) begin
                    w_push      = w_has_space;
                    w_load_hold = !w_has_space;
                end
            end
            S_PENDING: begin
                w_push      = w_pop;
                w_push_hold = w_pop;
                // a second toggle before our ack: drop the new word, keep the parked one
                w_set_error = w_toggle_det;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_sync     <= '0;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_error    <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_toggle};
            if (w_toggle_det) r_req_seen <= w_req_sync;
            if (w_push)       r_ack      <= ~r_ack;
            if (w_set_error)  r_error    <= 1'b1;
            if (w_load_hold)  r_hold     <= i_data_in;
        end
    end

    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_data;
    end

    assign o_ack_toggle     = r_ack;
    assign o_out_valid      = (r_count != '0);
    assign o_out_data       = r_mem[r_rd_ptr];
    assign o_fifo_count     = r_count;
    assign o_protocol_error = r_error;

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Bench for toggle_handshake_receiver: queue-based reference model checked every cycle,
// end-to-end order scoreboard, and literal checks on handshake latency and full/pending behaviour.
module tb_toggle_handshake_receiver;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic          clk = 1'b0;
    logic          clear;
    logic          req;
    logic [DW-1:0] din;
    logic          ack;
    logic          valid;
    logic [DW-1:0] dout;
    logic          ready;
    logic [2:0]    cnt;
    logic          perr;

    int n_checks = 0;
    int n_fail   = 0;

    toggle_handshake_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .i_clock(clk), .i_clear(clear), .i_req_toggle(req), .i_data_in(din),
        .o_ack_toggle(ack), .o_out_valid(valid), .o_out_data(dout), .i_out_ready(ready),
        .o_fifo_count(cnt), .o_protocol_error(perr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words held as a queue, request visible after a SYNC-deep delay line.
    logic [DW-1:0]   m_q[$];
    logic [SYNC-1:0] m_hist = '0;
    logic            m_seen = 1'b0;
    logic            m_pend = 1'b0;
    logic [DW-1:0]   m_hold = '0;
    logic            m_ack  = 1'b0;
    logic            m_err  = 1'b0;
    logic            m_det, m_pop, m_push;
    logic [DW-1:0]   m_w;

    always @(posedge clk) begin
        if (clear) begin
            m_q.delete();
            m_hist = '0; m_seen = 1'b0; m_pend = 1'b0; m_hold = '0; m_ack = 1'b0; m_err = 1'b0;
        end else begin
            m_det  = (m_hist[SYNC-1] != m_seen);
            m_pop  = (m_q.size() > 0) && ready;
            m_push = 1'b0;
            m_w    = din;
            if (!m_pend) begin
                if (m_det) begin
                    m_seen = m_hist[SYNC-1];
                    if (m_q.size() < DEPTH || m_pop) m_push = 1'b1;
                    else begin m_hold = din; m_pend = 1'b1; end
                end
            end else begin
                if (m_pop) begin m_push = 1'b1; m_w = m_hold; m_pend = 1'b0; end
                if (m_det) begin m_err = 1'b1; m_seen = m_hist[SYNC-1]; end
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) begin m_q.push_back(m_w); m_ack = ~m_ack; end
            m_hist = {m_hist[SYNC-2:0], req};
        end
    end

    // Words the sender expects to see delivered, in order.
    logic [DW-1:0] exp_q[$];
    bit started     = 1'b0;
    bit stream_mode = 1'b0;

    always @(negedge clk) begin
        if (started && !clear) begin
            chk("ack", ack, m_ack);
            chk("valid", valid, m_q.size() != 0);
            chk("count", cnt, 32'(m_q.size()));
            chk("perr", perr, m_err);
            chk("count_le_depth", cnt <= DEPTH, 1);
            if (valid && m_q.size() != 0) chk("data", dout, m_q[0]);
            if (stream_mode) chk("stream_count_le1", cnt <= 1, 1);
            if (valid && ready) begin
                if (exp_q.size() == 0) chk("unexpected_pop", dout, 32'hFFFF_FFFF);
                else begin
                    chk("order", dout, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit deliver);
        din = d;
        req = ~req;
        if (deliver) exp_q.push_back(d);
    endtask

    task automatic wait_ack(input int budget);
        int i = 0;
        while (ack !== req && i < budget) begin tick(1); i++; end
        chk("ack_wait", ack, req);
    endtask

    task automatic drain();
        int i = 0;
        ready = 1'b1;
        while (valid && i < 60) begin tick(1); i++; end
        ready = 1'b0;
        chk("drain_empty", cnt, 0);
    endtask

    bit done;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b1; req = 1'b0; din = '0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ack", ack, 0); chk("rst_valid", valid, 0);
        chk("rst_count", cnt, 0); chk("rst_perr", perr, 0);
        clear = 1'b0;
        started = 1'b1;
        tick(2);

        // single word: ack/data appear SYNC edges after the first sampling edge
        send(8'hA5, 1);
        tick(1); chk("t2_ack_k", ack, 0);
        tick(1); chk("t2_ack_k1", ack, 0);
        tick(1);
        chk("t2_ack", ack, 1); chk("t2_valid", valid, 1);
        chk("t2_data", dout, 8'hA5); chk("t2_count", cnt, 1);
        drain();

        // fill, then one word parked while full
        send(8'h11, 1); wait_ack(20);
        send(8'h22, 1); wait_ack(20);
        send(8'h33, 1); wait_ack(20);
        send(8'h44, 1); wait_ack(20);
        chk("t3_count4", cnt, 4); chk("t3_ack", ack, 1);
        send(8'h55, 1);
        tick(6);
        chk("t3_no_ack", ack, 1); chk("t3_count_full", cnt, 4); chk("t3_head", dout, 8'h11);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("t3_ack_on_pop", ack, 0); chk("t3_count_stays", cnt, 4); chk("t3_next_head", dout, 8'h22);
        drain();

        // streaming with the consumer always ready
        stream_mode = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(8'h60 + 8'(i), 1);
            wait_ack(20);
        end
        tick(4);
        stream_mode = 1'b0;
        ready = 1'b0;
        chk("t4_empty", cnt, 0); chk("t4_ack_parity", ack, 0); chk("t4_all_rx", exp_q.size(), 0);

        // protocol violation while a word is parked
        for (int i = 1; i <= 4; i++) begin
            send(8'h80 + 8'(i), 1);
            wait_ack(20);
        end
        send(8'h85, 1);
        tick(6);
        chk("t5_perr_before", perr, 0);
        send(8'hEE, 0);
        tick(SYNC + 2);
        chk("t5_perr", perr, 1); chk("t5_count", cnt, 4);
        drain();
        chk("t5_perr_sticky", perr, 1); chk("t5_all_rx", exp_q.size(), 0);

        // asynchronous clear mid-run, with words buffered and ack set
        send(8'h91, 0); tick(4);
        send(8'h92, 0); tick(5);
        chk("t1_pre_count", cnt, 2); chk("t1_pre_ack", ack, 1);
        #1;
        clear = 1'b1;
        req = 1'b0;
        #1;
        chk("t1_ack", ack, 0); chk("t1_valid", valid, 0);
        chk("t1_count", cnt, 0); chk("t1_perr", perr, 0);
        exp_q.delete();
        tick(2);
        clear = 1'b0;
        tick(2);

        // pointer wrap with random consumer back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * DEPTH; i++) begin
                    send(8'($urandom_range(0, 255)), 1);
                    wait_ack(200);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        drain();
        chk("t6_all_rx", exp_q.size(), 0);
        chk("t6_perr", perr, 0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
